// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory slice: access-width codes and the
// clear/ready state type.
package dm_pkg;

    typedef enum logic [2:0] {
        DM_W  = 3'd0,
        DM_H  = 3'd1,
        DM_HU = 3'd2,
        DM_B  = 3'd3,
        DM_BU = 3'd4
    } dm_op_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dm_state_e;

    // Codes 5..7 have no meaning of their own and behave as word accesses.
    function automatic dm_op_e dm_op_decode(input logic [2:0] code);
        case (code)
            3'd1:    return DM_H;
            3'd2:    return DM_HU;
            3'd3:    return DM_B;
            3'd4:    return DM_BU;
            default: return DM_W;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane selection and sign/zero extension of a stored 32-bit word.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  dm_op_e      op,
    input  logic [1:0]  lane,
    output logic [31:0] data
);

    logic [15:0] half_sel;
    logic [31:0] shifted;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = lane[1] ? word[31:16] : word[15:0];
        shifted  = word >> {lane, 3'b000};
        byte_sel = shifted[7:0];
        data     = word;
        case (op)
            DM_H:    data = {{16{half_sel[15]}}, half_sel};
            DM_HU:   data = {16'h0000, half_sel};
            DM_B:    data = {{24{byte_sel[7]}}, byte_sel};
            DM_BU:   data = {24'h000000, byte_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dm_byte_clr.sv
// Byte-addressable data memory that zeroes itself with a one-word-per-cycle
// sweep after reset, then serves combinational loads and clocked stores.
module dm_byte_clr
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter bit          TRACE       = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [2:0]  op,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        exc_misalign,
    output logic        exc_range
);

    localparam int unsigned     AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH_WORDS - 1);

    dm_state_e     state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic [31:0]   mem_q [DEPTH_WORDS];

    dm_op_e        op_n;
    logic [31:0]   offset, word_idx, cur_word, merged, ext_data;
    logic [AW-1:0] widx;
    logic          access, in_range, misalign, store_ok, load_ok;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    assign busy = (state_q == ST_CLEAR);
    assign op_n = dm_op_decode(op);

    always_comb begin
        offset   = addr - ADDR_BASE;
        word_idx = offset >> 2;
        widx     = word_idx[AW-1:0];
        in_range = (addr >= ADDR_BASE) && (word_idx < DEPTH_WORDS);
        cur_word = in_range ? mem_q[widx] : '0;
        access   = wr_en | rd_en;
        case (op_n)
            DM_W:         misalign = (addr[1:0] != 2'b00);
            DM_H, DM_HU:  misalign = addr[0];
            default:      misalign = 1'b0;
        endcase
        exc_range    = access & ~busy & ~in_range;
        exc_misalign = access & ~busy & misalign;
        store_ok     = wr_en & ~busy & in_range & ~misalign;
        load_ok      = rd_en & ~busy & in_range & ~misalign;
    end

    // Read-modify-write merge of the addressed word; untouched lanes keep old bytes.
    always_comb begin
        merged = cur_word;
        case (op_n)
            DM_H, DM_HU: begin
                if (addr[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            DM_B, DM_BU: merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
            default:     merged = wdata;
        endcase
    end

    dm_load_ext u_load_ext (
        .word (cur_word),
        .op   (op_n),
        .lane (addr[1:0]),
        .data (ext_data)
    );

    assign rdata = load_ok ? ext_data : '0;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_READY;
                    clr_idx_d = '0;
                end
            end
            default: begin
                if (store_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = widx;
                    mem_wdata = merged;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        end
    end

    generate
        if (TRACE) begin : g_trace
            always_ff @(posedge clk) begin
                if (reset_n && store_ok)
                    $display("@%08h: *%08h <= %08h", pc, {addr[31:2], 2'b00}, merged);
            end
        end
    endgenerate

endmodule
